// File: rtl/breadboard_sweep_ctrl_if.sv
// Signal bundle between a breadboard sweep controller and whatever drives it.
// The slave side is the controller; the master side is the requester/breadboard.
interface breadboard_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic [3:0]  wxyz;
    logic [9:0]  bb_r;
    logic        busy;
    logic        done;
    logic [15:0] row_valid;
    logic [3:0]  rd_addr;
    logic [9:0]  rd_data;
    logic [3:0]  col_sel;
    logic [15:0] col_mask;

    modport master (
        output start, abort, bb_r, rd_addr, col_sel,
        input  wxyz, busy, done, row_valid, rd_data, col_mask
    );

    modport slave (
        input  start, abort, bb_r, rd_addr, col_sel,
        output wxyz, busy, done, row_valid, rd_data, col_mask
    );
endinterface

// File: rtl/breadboard_sweep_ctrl.sv
// Drives all 16 wxyz input combinations onto a breadboard, waits for it to settle,
// and captures the 10 outputs of each row into a readable truth table.
//
// state   | meaning
// IDLE    | waiting for start
// SETTLE  | row driven, counting down settle time
// CAPTURE | latch bb_r into table[row], advance to next row
// DONE    | one-cycle completion pulse, release stimulus
module breadboard_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    breadboard_sweep_ctrl_if.slave bus
);

    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    state_t           state;
    logic [3:0]       row;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       tbl [16];
    logic [3:0]       wxyz_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      valid_q;
    logic [9:0]       rd_q;
    logic [15:0]      mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            row     <= '0;
            cnt     <= '0;
            wxyz_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= '0;
            rd_q    <= '0;
            for (int i = 0; i < 16; i++) tbl[i] <= '0;
        end else begin
            // Read port sees the table before any capture on this same edge.
            rd_q   <= tbl[bus.rd_addr];
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state   <= SETTLE;
                        row     <= '0;
                        wxyz_q  <= '0;
                        cnt     <= CNT_LOAD;
                        valid_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        wxyz_q <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        wxyz_q <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        tbl[row]     <= bus.bb_r;
                        valid_q[row] <= 1'b1;
                        if (row == 4'd15) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            row    <= row + 4'd1;
                            wxyz_q <= row + 4'd1;
                            cnt    <= CNT_LOAD;
                            state  <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    wxyz_q <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mask = '0;
        if (bus.col_sel <= 4'd9) begin
            for (int i = 0; i < 16; i++) mask[i] = tbl[i][bus.col_sel];
        end
    end

    assign bus.wxyz      = wxyz_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.row_valid = valid_q;
    assign bus.rd_data   = rd_q;
    assign bus.col_mask  = mask;

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Randomized bench for breadboard_sweep_ctrl: a simulated breadboard answers each
// wxyz row, and expectations come from the sweep timing rules and a table model.
module tb_breadboard_sweep_ctrl;

    localparam int S   = 4;
    localparam int PER = S + 1;
    localparam int END = 16 * PER;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    breadboard_sweep_ctrl_if bif ();

    breadboard_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    logic [9:0]  truth   [16];
    logic [9:0]  exp_tbl [16];
    logic [15:0] exp_valid;
    int          checks = 0;
    int          errors = 0;

    always_comb bif.bb_r = truth[bif.wxyz];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_mask(input logic [3:0] c);
        logic [15:0] m;
        m = '0;
        if (c <= 4'd9)
            for (int i = 0; i < 16; i++) m[i] = exp_tbl[i][c];
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) exp_tbl[i] = '0;
        exp_valid = '0;
    endtask

    // abort_at: edge offset from the start edge at which abort is sampled (0 = none).
    task automatic run_sweep(input int abort_at, input bit noise);
        logic [9:0]  rd_exp;
        logic [3:0]  exp_wxyz;
        bit          aborted;
        aborted      = 1'b0;
        bif.start    = 1'b1;
        bif.abort    = 1'b0;
        bif.rd_addr  = 4'($urandom_range(0, 15));
        bif.col_sel  = 4'($urandom_range(0, 15));
        rd_exp       = exp_tbl[bif.rd_addr];
        @(posedge clk); #1;
        bif.start = 1'b0;
        exp_valid = '0;
        chk("busy_rise", bif.busy, 1);
        chk("start_wxyz", bif.wxyz, 0);
        chk("start_valid", bif.row_valid, 0);
        chk("start_rd", bif.rd_data, rd_exp);
        for (int k = 1; k <= END + 1 && !aborted; k++) begin
            bif.abort   = (k == abort_at);
            bif.start   = noise ? ($urandom_range(0, 5) == 0) : 1'b0;
            bif.rd_addr = 4'($urandom_range(0, 15));
            bif.col_sel = 4'($urandom_range(0, 15));
            rd_exp      = exp_tbl[bif.rd_addr];
            @(posedge clk); #1;
            bif.abort = 1'b0;
            if (k == abort_at) begin
                aborted = 1'b1;
            end else if (k % PER == 0 && k <= END) begin
                exp_tbl[k / PER - 1]   = truth[k / PER - 1];
                exp_valid[k / PER - 1] = 1'b1;
            end
            if (aborted || k > END) exp_wxyz = 4'd0;
            else if (k / PER > 15)  exp_wxyz = 4'd15;
            else                    exp_wxyz = 4'(k / PER);
            chk("busy", bif.busy, (!aborted && k < END) ? 1 : 0);
            chk("done", bif.done, (!aborted && k == END) ? 1 : 0);
            chk("wxyz", bif.wxyz, exp_wxyz);
            chk("row_valid", bif.row_valid, exp_valid);
            chk("rd_data", bif.rd_data, rd_exp);
            chk("col_mask", bif.col_mask, model_mask(bif.col_sel));
        end
        bif.start = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", bif.busy, 0);
        chk("idle_done", bif.done, 0);
        chk("idle_wxyz", bif.wxyz, 0);
    endtask

    initial begin
        logic [15:0] m0;
        logic [15:0] m1;
        int          ab;
        m0 = 16'hFAC8;
        m1 = 16'hF8A8;
        bif.start   = 1'b0;
        bif.abort   = 1'b0;
        bif.rd_addr = 4'd0;
        bif.col_sel = 4'd0;
        for (int i = 0; i < 16; i++) truth[i] = '0;
        model_clear();

        #2;
        chk("rst_busy", bif.busy, 0);
        chk("rst_done", bif.done, 0);
        chk("rst_wxyz", bif.wxyz, 0);
        chk("rst_valid", bif.row_valid, 0);
        chk("rst_rd", bif.rd_data, 0);
        chk("rst_mask", bif.col_mask, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full sweep with r0/r1 wired to two fixed functions, r2..r9 tied low.
        for (int i = 0; i < 16; i++) truth[i] = {8'b0, m1[i], m0[i]};
        run_sweep(0, 1'b0);
        chk("full_valid", bif.row_valid, 16'hFFFF);
        bif.col_sel = 4'd0;  #1; chk("mask_c0", bif.col_mask, 16'hFAC8);
        bif.col_sel = 4'd1;  #1; chk("mask_c1", bif.col_mask, 16'hF8A8);
        bif.col_sel = 4'd12; #1; chk("mask_c12", bif.col_mask, 16'h0000);
        bif.rd_addr = 4'd3; @(posedge clk); #1; chk("rd3", bif.rd_data, 10'h003);
        bif.rd_addr = 4'd5; @(posedge clk); #1; chk("rd5", bif.rd_data, 10'h002);
        bif.rd_addr = 4'd6; @(posedge clk); #1; chk("rd6", bif.rd_data, 10'h001);
        bif.rd_addr = 4'd9; @(posedge clk); #1; chk("rd9", bif.rd_data, 10'h001);

        // Abort during settle of row 5, with stray start pulses before it.
        for (int i = 0; i < 16; i++) truth[i] = 10'($urandom);
        run_sweep(5 * PER + 2, 1'b1);
        chk("abort_valid", bif.row_valid, 16'h001F);

        // start and abort together in IDLE: abort wins; start alone next cycle sweeps.
        bif.start = 1'b1;
        bif.abort = 1'b1;
        @(posedge clk); #1;
        bif.abort = 1'b0;
        chk("both_busy", bif.busy, 0);
        for (int i = 0; i < 16; i++) truth[i] = 10'($urandom);
        run_sweep(0, 1'b0);

        // Randomized sweeps with random truth tables and random abort points.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++) truth[i] = 10'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, END));
            run_sweep(ab, 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            chk("gap_busy", bif.busy, 0);
        end

        // Reset in the middle of capturing row 7.
        bif.start = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        repeat (8 * PER - 1) @(posedge clk);
        #1;
        chk("pre_rst_wxyz", bif.wxyz, 7);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("mid_rst_busy", bif.busy, 0);
        chk("mid_rst_done", bif.done, 0);
        chk("mid_rst_wxyz", bif.wxyz, 0);
        chk("mid_rst_valid", bif.row_valid, 0);
        chk("mid_rst_rd", bif.rd_data, 0);
        bif.col_sel = 4'd0; #1;
        chk("mid_rst_mask", bif.col_mask, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2 * PER; k++) begin
            bif.rd_addr = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            chk("post_rst_busy", bif.busy, 0);
            chk("post_rst_done", bif.done, 0);
            chk("post_rst_wxyz", bif.wxyz, 0);
            chk("post_rst_rd", bif.rd_data, 0);
        end
        chk("post_rst_valid", bif.row_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
